// File: rtl/qe_m_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : qe_m_arbiter_if
// Description : Requester-side and QE_M-side bundle for qe_m_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface qe_m_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   req_mode;
   logic [N_REQ-1:0]   req_last;
   logic [8*N_REQ-1:0] req_a;
   logic [8*N_REQ-1:0] req_b;
   logic [8*N_REQ-1:0] req_c;
   logic [8*N_REQ-1:0] req_x;

   logic               qe_valid_in;
   logic               qe_last_input;
   logic               qe_mode;
   logic [7:0]         qe_a;
   logic [7:0]         qe_b;
   logic [7:0]         qe_c;
   logic [7:0]         qe_x;
   logic               qe_valid_out;
   logic [15:0]        qe_result;

   logic [N_REQ-1:0]   rsp_valid;
   logic [15:0]        rsp_result;

   modport master (
      input  req_valid, req_mode, req_last, req_a, req_b, req_c, req_x,
      output req_ready,
      output qe_valid_in, qe_last_input, qe_mode, qe_a, qe_b, qe_c, qe_x,
      input  qe_valid_out, qe_result,
      output rsp_valid, rsp_result
   );

   modport slave (
      output req_valid, req_mode, req_last, req_a, req_b, req_c, req_x,
      input  req_ready,
      input  qe_valid_in, qe_last_input, qe_mode, qe_a, qe_b, qe_c, qe_x,
      output qe_valid_out, qe_result,
      input  rsp_valid, rsp_result
   );
endinterface
`default_nettype wire

// File: rtl/qe_m_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qe_m_arbiter
// Description : Round-robin share of one QE_M datapath with MAC-burst locking
//               and tag-based result routing. QEM_ARB_ERR_EN adds err/err_code.
// Revision    : 1.0 - initial release
// ============================================================================
module qe_m_arbiter #(
   parameter int N_REQ      = 4,
   parameter int TAG_W      = 2,
   parameter int QE_LATENCY = 3
) (
   input  wire logic       clk,
   input  wire logic       reset,
   qe_m_arbiter_if.master  bus
`ifdef QEM_ARB_ERR_EN
   ,
   output logic            err,
   output logic [1:0]      err_code
`endif
);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_LOCK = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] owner_q, owner_d;

   logic             qe_valid_q, qe_mode_q, qe_last_q;
   logic [7:0]       qe_a_q, qe_b_q, qe_c_q, qe_x_q;
   logic [TAG_W-1:0] qe_tag_q;

   logic             exp_q [QE_LATENCY];
   logic [TAG_W-1:0] tag_q [QE_LATENCY];

   logic [TAG_W-1:0] w_cand;
   logic [TAG_W-1:0] w_grant_idx;
   logic             w_grant_any;
   logic [N_REQ-1:0] w_ready;
   logic [TAG_W-1:0] w_sel;
   logic             w_xfer;
   logic             w_sel_mode;
   logic             w_sel_last;
   logic             w_eff_mode;
   logic             w_load_exp;
   logic             w_head_exp;
   logic [TAG_W-1:0] w_head_tag;
   logic [N_REQ-1:0] w_rsp_valid;

   function automatic logic [TAG_W-1:0] f_wrap(input int v);
      return TAG_W'((v >= N_REQ) ? (v - N_REQ) : v);
   endfunction

   // First valid requester at or after rr_ptr: scan downward so the nearest wins.
   always_comb begin
      w_cand      = '0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = f_wrap(int'(rr_ptr_q) + k);
         if (bus.req_valid[w_cand]) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      w_sel   = w_grant_idx;
      if (state_q == c_LOCK) begin
         w_sel            = owner_q;
         w_ready[owner_q] = bus.req_valid[owner_q];
      end else if (w_grant_any) begin
         w_ready[w_grant_idx] = 1'b1;
      end
   end

   assign bus.req_ready = w_ready;
   assign w_xfer        = |(w_ready & bus.req_valid);
   assign w_sel_mode    = bus.req_mode[w_sel];
   assign w_sel_last    = bus.req_last[w_sel];
   assign w_eff_mode    = (state_q == c_LOCK) | w_sel_mode;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      if (w_xfer) begin
         if (state_q == c_LOCK) begin
            if (w_sel_last) begin
               state_d  = c_IDLE;
               rr_ptr_d = f_wrap(int'(owner_q) + 1);
            end
         end else if (w_sel_mode && !w_sel_last) begin
            state_d = c_LOCK;
            owner_d = w_grant_idx;
         end else begin
            rr_ptr_d = f_wrap(int'(w_grant_idx) + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= c_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   // Operands hold between transfers; only qe_valid_in drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         qe_valid_q <= 1'b0;
         qe_mode_q  <= 1'b0;
         qe_last_q  <= 1'b0;
         qe_a_q     <= '0;
         qe_b_q     <= '0;
         qe_c_q     <= '0;
         qe_x_q     <= '0;
         qe_tag_q   <= '0;
      end else begin
         qe_valid_q <= w_xfer;
         if (w_xfer) begin
            qe_mode_q <= w_eff_mode;
            qe_last_q <= w_sel_last;
            qe_a_q    <= bus.req_a[{w_sel, 3'b000} +: 8];
            qe_b_q    <= bus.req_b[{w_sel, 3'b000} +: 8];
            qe_c_q    <= bus.req_c[{w_sel, 3'b000} +: 8];
            qe_x_q    <= bus.req_x[{w_sel, 3'b000} +: 8];
            qe_tag_q  <= w_sel;
         end
      end
   end

   assign bus.qe_valid_in   = qe_valid_q;
   assign bus.qe_mode       = qe_mode_q;
   assign bus.qe_last_input = qe_last_q;
   assign bus.qe_a          = qe_a_q;
   assign bus.qe_b          = qe_b_q;
   assign bus.qe_c          = qe_c_q;
   assign bus.qe_x          = qe_x_q;

   // Only evaluate beats and the closing MAC beat produce a result.
   assign w_load_exp = qe_valid_q & (~qe_mode_q | qe_last_q);

   generate
      for (genvar s = 0; s < QE_LATENCY; s++) begin : g_tag_pipe
         if (s == 0) begin : g_load
            always_ff @(posedge clk) begin
               if (reset) begin
                  exp_q[0] <= 1'b0;
                  tag_q[0] <= '0;
               end else begin
                  exp_q[0] <= w_load_exp;
                  tag_q[0] <= qe_tag_q;
               end
            end
         end else begin : g_shift
            always_ff @(posedge clk) begin
               if (reset) begin
                  exp_q[s] <= 1'b0;
                  tag_q[s] <= '0;
               end else begin
                  exp_q[s] <= exp_q[s-1];
                  tag_q[s] <= tag_q[s-1];
               end
            end
         end
      end
   endgenerate

   assign w_head_exp = exp_q[QE_LATENCY-1];
   assign w_head_tag = tag_q[QE_LATENCY-1];

   always_comb begin
      w_rsp_valid = '0;
      if (bus.qe_valid_out && w_head_exp) begin
         w_rsp_valid[w_head_tag] = 1'b1;
      end
   end

   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_result = bus.qe_result;

`ifdef QEM_ARB_ERR_EN
   logic       err_q;
   logic [1:0] err_code_q;
   logic [1:0] w_err_code;

   always_comb begin
      w_err_code = 2'b00;
      if (bus.qe_valid_out && !w_head_exp) begin
         w_err_code = 2'b01;
      end else if (w_head_exp && !bus.qe_valid_out) begin
         w_err_code = 2'b10;
      end else if ((state_q == c_LOCK) && bus.req_valid[owner_q] && !bus.req_mode[owner_q]) begin
         w_err_code = 2'b11;
      end
   end

   // The first error's code sticks; later ones are absorbed by err alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else if ((w_err_code != 2'b00) && !err_q) begin
         err_q      <= 1'b1;
         err_code_q <= w_err_code;
      end
   end

   assign err      = err_q;
   assign err_code = err_code_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qe_m_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qe_m_arbiter
// Description : Scoreboard bench for qe_m_arbiter with a QE_M datapath model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qe_m_arbiter;
   localparam int N   = 4;
   localparam int TW  = 2;
   localparam int LAT = 3;

   typedef struct {
      int          idx;
      logic [15:0] res;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   qe_m_arbiter_if #(.N_REQ(N)) ifc ();

`ifdef QEM_ARB_ERR_EN
   logic       err;
   logic [1:0] err_code;
`endif

   qe_m_arbiter #(.N_REQ(N), .TAG_W(TW), .QE_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
`ifdef QEM_ARB_ERR_EN
      ,
      .err      (err),
      .err_code (err_code)
`endif
   );

   logic [N-1:0] tv = '0, tm = '0, tl = '0;
   logic [7:0]   op_a [N];
   logic [7:0]   op_b [N];
   logic [7:0]   op_c [N];
   logic [7:0]   op_x [N];
   bit           pend [N];
   int           rem  [N];

   assign ifc.req_valid = tv;
   assign ifc.req_mode  = tm;
   assign ifc.req_last  = tl;
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pack
         assign ifc.req_a[8*gi +: 8] = op_a[gi];
         assign ifc.req_b[8*gi +: 8] = op_b[gi];
         assign ifc.req_c[8*gi +: 8] = op_c[gi];
         assign ifc.req_x[8*gi +: 8] = op_x[gi];
      end
   endgenerate

   // QE_M datapath stand-in: fixed latency, MAC accumulates until the last beat.
   logic        dl_v [LAT] = '{default: 1'b0};
   logic [15:0] dl_r [LAT] = '{default: 16'h0};
   logic [15:0] qacc = 16'h0;
   bit          force_orphan = 1'b0;

   always @(posedge clk) begin
      dl_v[0] <= 1'b0;
      if (ifc.qe_valid_in) begin
         if (!ifc.qe_mode) begin
            dl_v[0] <= 1'b1;
            dl_r[0] <= 16'(ifc.qe_a) * 16'(ifc.qe_x) * 16'(ifc.qe_x)
                       + 16'(ifc.qe_b) * 16'(ifc.qe_x) + 16'(ifc.qe_c);
         end else if (ifc.qe_last_input) begin
            dl_v[0] <= 1'b1;
            dl_r[0] <= qacc + 16'(ifc.qe_a) * 16'(ifc.qe_x);
            qacc    <= 16'h0;
         end else begin
            qacc <= qacc + 16'(ifc.qe_a) * 16'(ifc.qe_x);
         end
      end
      for (int i = 1; i < LAT; i++) begin
         dl_v[i] <= dl_v[i-1];
         dl_r[i] <= dl_r[i-1];
      end
      if (reset) qacc <= 16'h0;
   end

   assign ifc.qe_valid_out = dl_v[LAT-1] | force_orphan;
   assign ifc.qe_result    = dl_r[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   // Reference model: arbitration rules applied to the requesters' view.
   int           m_rr    = 0;
   int           m_owner = 0;
   bit           m_lock  = 1'b0;
   logic [15:0]  m_acc   = 16'h0;
   bit           p_xfer  = 1'b0;
   logic [33:0]  p_qe    = '0;
   exp_t         sbq [$];

   function automatic int pick();
      if (m_lock) return tv[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (tv[(m_rr + k) % N]) return (m_rr + k) % N;
      end
      return -1;
   endfunction

   task automatic push_exp(input int g, input logic [15:0] r);
      exp_t e;
      e.idx = g;
      e.res = r;
      e.due = cyc + 1 + LAT;
      sbq.push_back(e);
   endtask

   task automatic apply(input int g);
      bit eff;
      eff  = m_lock ? 1'b1 : tm[g];
      p_qe = {op_a[g], op_b[g], op_c[g], op_x[g], eff, tl[g]};
      if (!eff) begin
         push_exp(g, 16'(op_a[g]) * 16'(op_x[g]) * 16'(op_x[g])
                     + 16'(op_b[g]) * 16'(op_x[g]) + 16'(op_c[g]));
         m_rr = (g + 1) % N;
      end else begin
         m_acc = m_acc + 16'(op_a[g]) * 16'(op_x[g]);
         if (tl[g]) begin
            push_exp(g, m_acc);
            m_acc  = 16'h0;
            m_lock = 1'b0;
            m_rr   = (g + 1) % N;
         end else if (!m_lock) begin
            m_lock  = 1'b1;
            m_owner = g;
         end
      end
   endtask

   task automatic cycle(output int g);
      @(negedge clk);
      check("qe_valid_in", 64'(ifc.qe_valid_in), 64'(p_xfer));
      if (p_xfer) begin
         check("qe_operands", 64'({ifc.qe_a, ifc.qe_b, ifc.qe_c, ifc.qe_x,
                                   ifc.qe_mode, ifc.qe_last_input}), 64'(p_qe));
      end
      g = -1;
      if (reset) begin
         m_rr = 0; m_lock = 1'b0; m_acc = 16'h0; p_xfer = 1'b0;
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due > cyc) sbq.delete(i);
         end
      end else begin
         g = pick();
         check("req_ready", 64'(ifc.req_ready), 64'((g >= 0) ? oh(g) : '0));
         p_xfer = (g >= 0);
         if (g >= 0) apply(g);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input bit md, input bit ls,
                         input int a, input int b, input int c, input int x);
      tm[i] = md; tl[i] = ls;
      op_a[i] = 8'(a); op_b[i] = 8'(b); op_c[i] = 8'(c); op_x[i] = 8'(x);
      tv[i] = 1'b1;
   endtask

   task automatic do_reset();
      int g;
      tv = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      reset = 1'b1;
      cycle(g);
      reset = 1'b0;
   endtask

   task automatic gen(input int g, input bit allow_new);
      for (int i = 0; i < N; i++) begin
         if (g == i) begin
            if (rem[i] > 1) begin
               rem[i]--;
               op_a[i] = 8'($urandom); op_x[i] = 8'($urandom);
               tl[i] = (rem[i] == 1);
               tv[i] = ($urandom_range(3) != 0);
            end else begin
               pend[i] = 1'b0;
               tv[i]   = 1'b0;
            end
         end else if (pend[i] && !tv[i]) begin
            tv[i] = ($urandom_range(2) != 0);
         end
         if (!pend[i] && allow_new && $urandom_range(9) < 4) begin
            pend[i] = 1'b1;
            tm[i]   = 1'($urandom);
            rem[i]  = tm[i] ? $urandom_range(3, 1) : 1;
            set_op(i, tm[i], tm[i] ? (rem[i] == 1) : 1'($urandom),
                   int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(255)), int'($urandom_range(255)));
         end
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (ifc.rsp_valid !== '0) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: actual rsp_valid=%b result=%0d, required none (cycle %0d)",
                     ifc.rsp_valid, ifc.rsp_result, cyc);
         end else begin
            e = sbq.pop_front();
            check("rsp", {12'h0, ifc.rsp_valid, ifc.rsp_result, 32'(cyc)},
                  {12'h0, oh(e.idx), e.res, 32'(e.due)});
         end
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         e = sbq.pop_front();
         check("rsp_missing", 64'(0), {12'h0, oh(e.idx), e.res, 32'(e.due)});
      end
   end

   initial begin : stim
      int g;
      int guard;
      bit any_pend;
      for (int i = 0; i < N; i++) begin
         op_a[i] = 8'h0; op_b[i] = 8'h0; op_c[i] = 8'h0; op_x[i] = 8'h0;
         pend[i] = 1'b0; rem[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_qe", 64'({ifc.qe_valid_in, ifc.qe_last_input, ifc.qe_mode,
                             ifc.qe_a, ifc.qe_b, ifc.qe_c, ifc.qe_x}), 64'(0));
      check("reset_ready", 64'(ifc.req_ready), 64'(0));
      check("reset_rsp", 64'(ifc.rsp_valid), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

`ifdef QEM_ARB_ERR_EN
      check("err_after_reset", 64'({err, err_code}), 64'(0));
      force_orphan = 1'b1;
      cycle(g);
      force_orphan = 1'b0;
      check("err_orphan", 64'({err, err_code}), 64'(3'b101));
`endif

      // Single evaluate: 1*16 + 2*4 + 3 = 27 from requester 0
      set_op(0, 1'b0, 1'b0, 1, 2, 3, 4);
      cycle(g);
      tv[0] = 1'b0;
      repeat (6) cycle(g);

      // All requesters streaming evaluates
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 1'b0, 1'b0, i + 5, i + 1, i * 3, i + 2);
      repeat (8) begin
         cycle(g);
         if (g >= 0) set_op(g, 1'b0, 1'b0, int'($urandom_range(255)), int'($urandom_range(255)),
                            int'($urandom_range(255)), int'($urandom_range(255)));
      end
      tv = '0;
      repeat (6) cycle(g);

      // MAC burst on requester 1 with a gap while requester 2 waits: 100*8 + 1*2
      do_reset();
      set_op(1, 1'b1, 1'b0, 100, 0, 0, 8);
      set_op(2, 1'b0, 1'b0, 5, 6, 7, 1);
      cycle(g);
      tv[1] = 1'b0;
      cycle(g);
      set_op(1, 1'b1, 1'b1, 1, 0, 0, 2);
      cycle(g);
      tv[1] = 1'b0;
      cycle(g);
      tv[2] = 1'b0;
      repeat (6) cycle(g);

      // Pointer wrap: grant 2 moves rr_ptr to 3, then 3 before 0
      do_reset();
      set_op(2, 1'b0, 1'b0, 9, 9, 9, 9);
      cycle(g);
      tv[2] = 1'b0;
      set_op(0, 1'b0, 1'b0, 2, 0, 1, 3);
      set_op(3, 1'b1, 1'b1, 7, 0, 0, 6);
      cycle(g);
      tv[3] = 1'b0;
      cycle(g);
      tv[0] = 1'b0;
      repeat (5) cycle(g);

      // Reset with two results in flight: both must vanish
      do_reset();
      set_op(0, 1'b0, 1'b0, 3, 4, 5, 6);
      set_op(1, 1'b0, 1'b0, 7, 8, 9, 10);
      cycle(g);
      cycle(g);
      tv = '0;
      cycle(g);
      do_reset();
      repeat (8) cycle(g);
      for (int i = 0; i < N; i++) set_op(i, 1'b0, 1'b0, i, i, i, i);
      cycle(g);
      tv = '0;
      repeat (6) cycle(g);

      // Randomized traffic
      do_reset();
      g = -1;
      repeat (1500) begin
         gen(g, 1'b1);
         cycle(g);
      end
      guard = 0;
      any_pend = 1'b1;
      while (any_pend && guard < 400) begin
         gen(g, 1'b0);
         any_pend = 1'b0;
         for (int i = 0; i < N; i++) any_pend |= pend[i];
         if (any_pend) cycle(g);
         guard++;
      end
      check("drain_done", 64'(any_pend), 64'(0));
      tv = '0;
      repeat (LAT + 4) cycle(g);
      check("scoreboard_empty", 64'(sbq.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/qe_m_arbiter.md
Name: qe_m_arbiter

Overview:
- Round-robin scheduler that shares one QE_M quadratic/MAC datapath between N_REQ requesters.
- Mode-0 (evaluate a·x²+b·x+c) operands are granted one transfer at a time.
- A mode-1 (MAC a·x) burst locks the datapath to one requester until its last_input beat.
- An in-flight tag pipeline returns each QE_M result to the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_W, 2, requester index width, equal to clog2(N_REQ).
- QE_LATENCY, 3, cycles from qe_valid_in sampled high to the matching qe_valid_out.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; combinational from state/pointer/req_valid.
- req_mode  in  N_REQ  0 = evaluate, 1 = MAC.
- req_last  in  N_REQ  last beat of a MAC burst.
- req_a, req_b, req_c, req_x  in  8*N_REQ each  packed operands, requester i at bits [8i+7:8i].
- qe_valid_in, qe_last_input, qe_mode  out  1  registered drive to QE_M.
- qe_a, qe_b, qe_c, qe_x  out  8 each  registered operands to QE_M.
- qe_valid_out  in  1  QE_M result valid.
- qe_result  in  16  QE_M result.
- rsp_valid  out  N_REQ  one-hot result strobe.
- rsp_result  out  16  qe_result broadcast to all requesters.

Behaviour:
- Reset values:
  - All qe_* outputs 0; req_ready 0; rsp_valid 0.
  - State IDLE; rr_ptr 0; tag pipeline cleared.
  - Reset mid-burst or mid-flight discards everything; no response is emitted for dropped work.
- Transfer definition: req_valid[i] & req_ready[i] at a posedge.
  - Next cycle: qe_valid_in=1 with the requester's operands, qe_mode and qe_last_input.
  - Cycles with no transfer drive qe_valid_in=0; operands hold their last values.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready is one-hot to that requester only.
  - Mode-0 transfer: stay IDLE; rr_ptr ← i+1 mod N_REQ.
  - Mode-1 transfer with req_last=1 (single-beat MAC): stay IDLE; rr_ptr ← i+1.
  - Mode-1 transfer with req_last=0: go to LOCK; owner ← i.
- LOCK:
  - req_ready = req_valid[owner] only; all other requesters are stalled.
  - qe_mode is forced to 1 and owner's req_mode is ignored.
  - Gaps (owner valid low) are legal; qe_valid_in=0 during gaps.
  - Transfer with req_last=1: go to IDLE; rr_ptr ← owner+1 mod N_REQ.
- Tag pipeline:
  - QE_LATENCY stages of {expect, tag}. The stage loaded on each posedge is expect=qe_valid_in&(~qe_mode|qe_last_input) with tag=index of the requester granted.
  - At the head: rsp_valid[head.tag] = qe_valid_out & head.expect, same cycle (combinational). rsp_result = qe_result.
  - qe_valid_out with head.expect=0 is an orphan and produces no rsp_valid.
  - head.expect=1 without qe_valid_out is a drop; the entry retires silently.
- Throughput: one transfer per cycle sustained, with back-to-back grants to different requesters in IDLE.
- Simultaneous requests: a single grant per cycle. No starvation: worst-case wait is N_REQ−1 grants, plus any locked bursts.

Optional Feature:
- Macro QEM_ARB_ERR_EN.
- When defined:
  - Adds output err (1 bit) and err_code (2 bits), both sticky until reset.
  - err_code 01 = orphan qe_valid_out; 10 = missing expected result.
  - err_code 11 = owner presented req_mode=0 with req_valid=1 during LOCK; that beat is still accepted as MAC.
  - The first error latches the code; later errors only keep err=1.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single mode-0 request, QE_LATENCY=3.
  - Stimulus: req0 a=1, b=2, c=3, x=4.
  - Response: qe_valid_in one cycle later; rsp_valid=4'b0001 with rsp_result=27, 3 cycles after qe_valid_in.
- All four requesters valid in mode 0 every cycle from reset.
  - Response: grants 0,1,2,3,0,… on consecutive cycles; each rsp_valid bit matches the issuing order.
- MAC burst with contention.
  - Stimulus: req1 sends (a=100, x=8, last=0), gap, then (a=1, x=2, last=1); req2 is valid throughout.
  - Response: req2 is not ready until after req1's last beat; a single rsp_valid[1] with 802; req2 is granted next.
- Reset mid-flight.
  - Stimulus: assert reset 1 cycle after issuing 2 mode-0 ops.
  - Response: no rsp_valid afterwards; rr_ptr=0; the next grant goes to req0.
- Wrap-around.
  - Stimulus: rr_ptr=3 with req0 and req3 valid.
  - Response: req3 is granted first, then req0.
- (QEM_ARB_ERR_EN defined) Orphan result.
  - Stimulus: force qe_valid_out=1 with an empty pipeline.
  - Response: err=1, err_code=01, no rsp_valid.
